reg_file_pn: RTL and testbench
==============================

// Module: reg_file_pn
// PURPOSE
//  Parametrised general-purpose register file for the next-generation scpu core.
//  Holds NREGS registers of WIDTH bits. Has one data-bus read/write port, two ALU read ports and an ALU write-back port.
//  The ALU write-back port has a one-stage commit pipeline with read forwarding.
//  Adds per-register and register-pair (pointer) increment/decrement, and pair outputs that drive the address bus.
//  Sits between the control unit, the ALU and the data/address buses; it replaces the discrete register instances.
// PARAMETERS
//  NREGS   8              number of registers; even, >=2
//  WIDTH   8              register width in bits; address bus width = 2*WIDTH
//  AW      $clog2(NREGS)  register index width (derived; do not override)
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  bus_we       in   1        data-bus write enable
//  bus_waddr    in   AW       data-bus write register index
//  bus_wdata    in   WIDTH    data-bus write value
//  bus_raddr    in   AW       data-bus read register index
//  bus_rdata    out  WIDTH    data-bus read value (combinational, forwarded)
//  alu_a_addr   in   AW       ALU operand A index
//  alu_b_addr   in   AW       ALU operand B index
//  alu_a_data   out  WIDTH    ALU operand A (combinational, forwarded)
//  alu_b_data   out  WIDTH    ALU operand B (combinational, forwarded)
//  alu_we       in   1        ALU result valid
//  alu_waddr    in   AW       ALU result destination index
//  alu_wdata    in   WIDTH    ALU result value
//  step_en      in   1        increment/decrement request
//  step_addr    in   AW       step target index (LSB ignored when step_pair=1)
//  step_dir     in   1        0 = +1, 1 = -1
//  step_pair    in   1        1 = 2*WIDTH-bit pair step on {r[2k], r[2k+1]}
//  pair_sel     in   AW-1     pair index k for pair_addr
//  pair_addr    out  2*WIDTH  {r[2k], r[2k+1]} (hi:lo, combinational, forwarded)
//  step_zero    out  1        registered; step result was zero
//  wb_pending   out  1        ALU write-back stage holds an uncommitted result
//  wr_collide   out  1        registered 1-cycle pulse; a lower-priority write was dropped
// BEHAVIOUR
//  Reset (async, rst_n=0): all registers <= 0; wb_valid, step_zero and wr_collide <= 0.
//   Reset mid-operation discards any pending write-back and any in-flight step.
//  ALU write-back: on an edge with alu_we=1, {alu_waddr, alu_wdata} is captured into the wb stage and wb_valid <= 1.
//   The stage commits to the array on the following edge. If alu_we=1 again, the new result enters the same edge.
//   Otherwise wb_valid <= 0. wb_pending = wb_valid.
//  Forwarding: every read port returns wb_data when wb_valid and the index matches; otherwise it returns array content.
//   Applied per half on pair_addr. A write issued this cycle is NOT visible until after the edge (no same-cycle bypass).
//  Bus write: bus_we=1 writes bus_wdata to r[bus_waddr] at the edge.
//  Step: a single step does r[i] <= r[i] +/- 1 mod 2^WIDTH.
//   A pair step treats {r[2k],r[2k+1]} as one 2*WIDTH value and does +/-1 mod 2^(2*WIDTH). Carry/borrow ripples lo->hi.
//   Step source operands use forwarded values.
//  Write priority per register (same edge, same target): bus write > wb commit > step.
//   Writes to different registers all take effect. A pair step collides on either half.
//   If any half loses, the whole pair step is dropped (never a partial pair update).
//   A dropped write sets wr_collide=1 for one cycle. A wb entry that loses is discarded, not retried.
//  step_zero <= (result==0) on every edge with step_en=1, even if the step was dropped.
//   It holds its value while step_en=0.
//  Wrap cases: single 0xFF +1 -> 0x00, step_zero=1. Pair 0x0000 -1 -> 0xFFFF.
//  Out-of-range indices (>= NREGS when NREGS is not a power of 2): writes ignored, reads return 0.
// TESTING
//  1 reset: write all regs, pulse rst_n low mid-cycle -> all reads 0 immediately, wb_pending=0, step_zero=0.
//  2 forwarding: alu_we r3=0x5A; next cycle alu_a_addr=3 -> 0x5A while wb_pending=1; array holds 0x5A after commit.
//  3 pair step: r4=0x12, r5=0xFF, step_pair inc k=2 -> r4=0x13, r5=0x00, pair_addr(sel 2)=0x1300, step_zero=0.
//  4 wrap: r6=r7=0x00, pair dec -> 0xFFFF; r1=0xFF single inc -> 0x00, step_zero=1.
//  5 collision: wb commit r2=0x11 with bus write r2=0x22 same edge -> r2=0x22, wr_collide pulses 1 cycle.
//  6 pair drop: step pair k=0 with bus write r1=0x40 same edge -> r0 unchanged, r1=0x40, wr_collide=1.

Source files
------------

// File: rtl/reg_file_pn_if.sv
// Register-file port bundle: data-bus read/write, two ALU read ports, ALU write-back,
// step (inc/dec) requests and the register-pair address output.
interface reg_file_pn_if #(
    parameter int NREGS = 8,
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(NREGS);
    localparam int PW = (AW > 1) ? AW - 1 : 1;

    logic                 bus_we;
    logic [AW-1:0]        bus_waddr;
    logic [WIDTH-1:0]     bus_wdata;
    logic [AW-1:0]        bus_raddr;
    logic [WIDTH-1:0]     bus_rdata;

    logic [AW-1:0]        alu_a_addr;
    logic [AW-1:0]        alu_b_addr;
    logic [WIDTH-1:0]     alu_a_data;
    logic [WIDTH-1:0]     alu_b_data;
    logic                 alu_we;
    logic [AW-1:0]        alu_waddr;
    logic [WIDTH-1:0]     alu_wdata;

    logic                 step_en;
    logic [AW-1:0]        step_addr;
    logic                 step_dir;
    logic                 step_pair;

    logic [PW-1:0]        pair_sel;
    logic [2*WIDTH-1:0]   pair_addr;

    logic                 step_zero;
    logic                 wb_pending;
    logic                 wr_collide;

    modport master (
        output bus_we, bus_waddr, bus_wdata, bus_raddr,
        output alu_a_addr, alu_b_addr, alu_we, alu_waddr, alu_wdata,
        output step_en, step_addr, step_dir, step_pair, pair_sel,
        input  bus_rdata, alu_a_data, alu_b_data, pair_addr,
        input  step_zero, wb_pending, wr_collide
    );

    modport slave (
        input  bus_we, bus_waddr, bus_wdata, bus_raddr,
        input  alu_a_addr, alu_b_addr, alu_we, alu_waddr, alu_wdata,
        input  step_en, step_addr, step_dir, step_pair, pair_sel,
        output bus_rdata, alu_a_data, alu_b_data, pair_addr,
        output step_zero, wb_pending, wr_collide
    );
endinterface

// File: rtl/reg_file_pn.sv
// General-purpose register file with forwarded ALU write-back stage, single/pair
// inc/dec and prioritised per-register writes (bus > write-back commit > step).
module reg_file_pn #(
    parameter int NREGS = 8,
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    reg_file_pn_if.slave  rf
);
    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0]   regs [NREGS];
    logic               wb_valid;
    logic [AW-1:0]      wb_addr;
    logic [WIDTH-1:0]   wb_data;
    logic               step_zero_q;
    logic               wr_collide_q;

    logic [AW-1:0]      pr_hi, pr_lo, st_hi, st_lo;
    logic [2*WIDTH-1:0] st_src, st_res;
    logic               st_zero, st_drop, wb_drop;
    logic [NREGS-1:0]   bus_hit, wb_hit, st_hit_hi, st_hit_lo;

    function automatic logic in_range(input logic [AW-1:0] idx);
        return int'(idx) < NREGS;
    endfunction

    function automatic logic [WIDTH-1:0] fwd_rd(input logic [AW-1:0] idx);
        if (!in_range(idx))
            return '0;
        if (wb_valid && wb_addr == idx)
            return wb_data;
        return regs[idx];
    endfunction

    always_comb begin
        pr_hi = AW'({rf.pair_sel, 1'b0});
        pr_lo = pr_hi | AW'(1);
        st_hi = rf.step_addr & ~AW'(1);
        st_lo = st_hi | AW'(1);

        // Step operands see the pending write-back, same as every read port.
        st_src = rf.step_pair ? {fwd_rd(st_hi), fwd_rd(st_lo)}
                              : {{WIDTH{1'b0}}, fwd_rd(rf.step_addr)};
        st_res = rf.step_dir ? st_src - (2*WIDTH)'(1) : st_src + (2*WIDTH)'(1);
        st_zero = rf.step_pair ? (st_res == '0) : (st_res[WIDTH-1:0] == '0);

        for (int j = 0; j < NREGS; j++) begin
            bus_hit[j] = rf.bus_we && (int'(rf.bus_waddr) == j);
            wb_hit[j]  = wb_valid && (int'(wb_addr) == j);
            if (rf.step_pair) begin
                st_hit_hi[j] = rf.step_en && (int'(st_hi) == j);
                st_hit_lo[j] = rf.step_en && (int'(st_lo) == j);
            end else begin
                st_hit_hi[j] = 1'b0;
                st_hit_lo[j] = rf.step_en && (int'(rf.step_addr) == j);
            end
        end

        // A pair step losing either half is dropped whole.
        st_drop = |((st_hit_hi | st_hit_lo) & (bus_hit | wb_hit));
        wb_drop = |(wb_hit & bus_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NREGS; j++)
                regs[j] <= '0;
            wb_valid     <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            step_zero_q  <= 1'b0;
            wr_collide_q <= 1'b0;
        end else begin
            wb_valid <= rf.alu_we;
            if (rf.alu_we) begin
                wb_addr <= rf.alu_waddr;
                wb_data <= rf.alu_wdata;
            end
            for (int j = 0; j < NREGS; j++) begin
                if (bus_hit[j])
                    regs[j] <= rf.bus_wdata;
                else if (wb_hit[j])
                    regs[j] <= wb_data;
                else if (!st_drop && st_hit_hi[j])
                    regs[j] <= st_res[2*WIDTH-1:WIDTH];
                else if (!st_drop && st_hit_lo[j])
                    regs[j] <= st_res[WIDTH-1:0];
            end
            if (rf.step_en)
                step_zero_q <= st_zero;
            wr_collide_q <= st_drop | wb_drop;
        end
    end

    always_comb begin
        rf.bus_rdata  = fwd_rd(rf.bus_raddr);
        rf.alu_a_data = fwd_rd(rf.alu_a_addr);
        rf.alu_b_data = fwd_rd(rf.alu_b_addr);
        rf.pair_addr  = {fwd_rd(pr_hi), fwd_rd(pr_lo)};
        rf.wb_pending = wb_valid;
        rf.step_zero  = step_zero_q;
        rf.wr_collide = wr_collide_q;
    end
endmodule

// File: tb/tb_reg_file_pn.sv
// Scoreboard bench for reg_file_pn: stimulus queues expected outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_reg_file_pn;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_pn_if #(.NREGS(8), .WIDTH(8)) rf ();
    reg_file_pn #(.NREGS(8), .WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .rf(rf.slave));

    typedef enum {K_BUS, K_A, K_B, K_PAIR, K_PEND, K_SZ, K_COL} kind_e;
    typedef struct {
        kind_e       kind;
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_out(input kind_e k, input string n, input logic [15:0] v);
        exp_t e;
        e.kind = k;
        e.name = n;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Advance to just after the next rising edge; write/step requests are one-shot.
    task automatic cyc();
        @(posedge clk);
        #1;
        rf.bus_we  = 1'b0;
        rf.alu_we  = 1'b0;
        rf.step_en = 1'b0;
    endtask

    task automatic bus_wr(input int a, input logic [7:0] d);
        rf.bus_we    = 1'b1;
        rf.bus_waddr = 3'(a);
        rf.bus_wdata = d;
    endtask

    task automatic alu_wr(input int a, input logic [7:0] d);
        rf.alu_we    = 1'b1;
        rf.alu_waddr = 3'(a);
        rf.alu_wdata = d;
    endtask

    task automatic step(input int a, input logic dir, input logic pair);
        rf.step_en   = 1'b1;
        rf.step_addr = 3'(a);
        rf.step_dir  = dir;
        rf.step_pair = pair;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_BUS:   act = {8'h00, rf.bus_rdata};
                K_A:     act = {8'h00, rf.alu_a_data};
                K_B:     act = {8'h00, rf.alu_b_data};
                K_PAIR:  act = rf.pair_addr;
                K_PEND:  act = {15'h0, rf.wb_pending};
                K_SZ:    act = {15'h0, rf.step_zero};
                default: act = {15'h0, rf.wr_collide};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rf.bus_we = 0; rf.bus_waddr = 0; rf.bus_wdata = 0; rf.bus_raddr = 0;
        rf.alu_a_addr = 0; rf.alu_b_addr = 0; rf.alu_we = 0; rf.alu_waddr = 0; rf.alu_wdata = 0;
        rf.step_en = 0; rf.step_addr = 0; rf.step_dir = 0; rf.step_pair = 0; rf.pair_sel = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_out(K_PEND, "init_pending", 16'h0);
        expect_out(K_SZ,   "init_step_zero", 16'h0);
        expect_out(K_COL,  "init_collide", 16'h0);
        expect_out(K_BUS,  "init_r0", 16'h0);
        cyc();

        // reset mid-operation
        for (int i = 0; i < 8; i++) begin
            bus_wr(i, (i < 7) ? 8'(8'h10 + i) : 8'hFF);
            cyc();
        end
        step(7, 1'b0, 1'b0);
        alu_wr(2, 8'h99);
        cyc();
        rf.bus_raddr = 7; rf.alu_a_addr = 2; rf.alu_b_addr = 3; rf.pair_sel = 2;
        expect_out(K_BUS,  "pre_rst_r7_wrap", 16'h0000);
        expect_out(K_SZ,   "pre_rst_step_zero", 16'h0001);
        expect_out(K_PEND, "pre_rst_pending", 16'h0001);
        expect_out(K_A,    "pre_rst_fwd_r2", 16'h0099);
        expect_out(K_B,    "pre_rst_r3", 16'h0013);
        expect_out(K_PAIR, "pre_rst_pair2", 16'h1415);
        alu_wr(2, 8'h98);
        cyc();
        rst_n = 1'b0;
        rf.bus_raddr = 3; rf.alu_a_addr = 2; rf.alu_b_addr = 5; rf.pair_sel = 3;
        expect_out(K_BUS,  "rst_r3", 16'h0);
        expect_out(K_A,    "rst_r2", 16'h0);
        expect_out(K_B,    "rst_r5", 16'h0);
        expect_out(K_PAIR, "rst_pair3", 16'h0);
        expect_out(K_PEND, "rst_pending", 16'h0);
        expect_out(K_SZ,   "rst_step_zero", 16'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // write-back forwarding
        alu_wr(3, 8'h5A);
        rf.alu_a_addr = 3;
        expect_out(K_A,    "fwd_no_bypass", 16'h0000);
        expect_out(K_PEND, "fwd_pending_before", 16'h0);
        cyc();
        rf.bus_raddr = 3;
        expect_out(K_A,    "fwd_a", 16'h005A);
        expect_out(K_BUS,  "fwd_bus", 16'h005A);
        expect_out(K_PEND, "fwd_pending", 16'h1);
        cyc();
        expect_out(K_A,    "fwd_committed", 16'h005A);
        expect_out(K_PEND, "fwd_pending_after", 16'h0);
        cyc();

        // pair increment with carry (LSB of step_addr ignored)
        bus_wr(4, 8'h12); cyc();
        bus_wr(5, 8'hFF); cyc();
        step(5, 1'b0, 1'b1); cyc();
        rf.pair_sel = 2; rf.bus_raddr = 4; rf.alu_a_addr = 5;
        expect_out(K_PAIR, "pair_inc", 16'h1300);
        expect_out(K_BUS,  "pair_inc_r4", 16'h0013);
        expect_out(K_A,    "pair_inc_r5", 16'h0000);
        expect_out(K_SZ,   "pair_inc_zero", 16'h0);
        cyc();

        // wrap cases
        step(6, 1'b1, 1'b1); cyc();
        rf.pair_sel = 3;
        expect_out(K_PAIR, "pair_dec_wrap", 16'hFFFF);
        expect_out(K_SZ,   "pair_dec_zero", 16'h0);
        bus_wr(1, 8'hFF);
        cyc();
        step(1, 1'b0, 1'b0); cyc();
        rf.bus_raddr = 1;
        expect_out(K_BUS,  "single_wrap", 16'h0000);
        expect_out(K_SZ,   "single_wrap_zero", 16'h1);
        cyc();
        expect_out(K_SZ,   "step_zero_hold", 16'h1);
        expect_out(K_COL,  "no_collide", 16'h0);
        cyc();

        // bus write beats write-back commit
        alu_wr(2, 8'h11); cyc();
        bus_wr(2, 8'h22);
        rf.alu_b_addr = 2;
        expect_out(K_B,    "col_fwd_r2", 16'h0011);
        expect_out(K_PEND, "col_pending", 16'h1);
        cyc();
        rf.bus_raddr = 2;
        expect_out(K_BUS,  "col_r2", 16'h0022);
        expect_out(K_COL,  "col_pulse", 16'h1);
        expect_out(K_PEND, "col_pending_after", 16'h0);
        cyc();
        expect_out(K_COL,  "col_pulse_end", 16'h0);
        expect_out(K_BUS,  "col_r2_hold", 16'h0022);
        cyc();

        // forwarding on each half of pair_addr
        alu_wr(6, 8'hAB); cyc();
        rf.pair_sel = 3;
        expect_out(K_PAIR, "pair_fwd", 16'hABFF);
        cyc();
        expect_out(K_PAIR, "pair_fwd_commit", 16'hABFF);
        cyc();

        // pair step dropped whole when one half loses
        bus_wr(0, 8'h33); cyc();
        bus_wr(1, 8'hFF); cyc();
        step(0, 1'b0, 1'b1);
        bus_wr(1, 8'h40);
        cyc();
        rf.bus_raddr = 0; rf.alu_a_addr = 1;
        expect_out(K_BUS,  "drop_r0", 16'h0033);
        expect_out(K_A,    "drop_r1", 16'h0040);
        expect_out(K_COL,  "drop_collide", 16'h1);
        expect_out(K_SZ,   "drop_zero", 16'h0);
        cyc();

        // writes to different registers all land
        bus_wr(2, 8'h77);
        step(3, 1'b1, 1'b0);
        cyc();
        rf.bus_raddr = 2; rf.alu_a_addr = 3;
        expect_out(K_BUS,  "indep_r2", 16'h0077);
        expect_out(K_A,    "indep_r3", 16'h0059);
        expect_out(K_COL,  "indep_collide", 16'h0);
        cyc();

        // commit beats step; step_zero uses forwarded source
        alu_wr(5, 8'hFF); cyc();
        step(5, 1'b0, 1'b0); cyc();
        rf.bus_raddr = 5;
        expect_out(K_BUS,  "wbstep_r5", 16'h00FF);
        expect_out(K_COL,  "wbstep_collide", 16'h1);
        expect_out(K_SZ,   "wbstep_zero", 16'h1);
        cyc();

        for (int i = 0; i < 4 && sb.size() != 0; i++)
            @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
